// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: direction encoding and a width helper
// used by elaboration-time parameter checks.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/counter_modulo8_sync_updown_if.sv
// Control/status bundle of the synchronous up/down counter; clock and clear stay
// separate ports on the counter itself.
interface counter_modulo8_sync_updown_if #(
  parameter int WIDTH = 3
);

  logic             enable;
  logic             count_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] signal_q;
  logic [WIDTH-1:0] signal_q_;
  logic             terminal_count;
  logic             load_error;

  modport master (
    output enable, count_down, load, load_value,
    input  signal_q, signal_q_, terminal_count, load_error
  );

  modport slave (
    input  enable, count_down, load, load_value,
    output signal_q, signal_q_, terminal_count, load_error
  );

endinterface

// File: rtl/flipflop_jk_posedge_sync.sv
// Rising-edge JK flip-flop with synchronous active-high clear and a complementary
// output.
module flipflop_jk_posedge_sync (
  input  logic clockpulse,
  input  logic clear,
  input  logic jack,
  input  logic kilby,
  output logic signal_q,
  output logic signal_q_
);

  logic q_reg;

  always_ff @(posedge clockpulse) begin
    if (clear) begin
      q_reg <= 1'b0;
    end else begin
      case ({jack, kilby})
        2'b01:   q_reg <= 1'b0;
        2'b10:   q_reg <= 1'b1;
        2'b11:   q_reg <= ~q_reg;
        default: q_reg <= q_reg;
      endcase
    end
  end

  assign signal_q  = q_reg;
  assign signal_q_ = ~q_reg;

endmodule

// File: rtl/counter_modulo8_sync_updown.sv
// Synchronous modulo-MODULUS up/down counter built from per-bit JK flip-flops, with
// parallel load, illegal-load flag and a cascadable terminal count.
module counter_modulo8_sync_updown
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic                          clockpulse,
  input  logic                          clear,
  counter_modulo8_sync_updown_if.slave  bus
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH) || clog2(MODULUS) > WIDTH) begin : g_bad_param
      $fatal(1, "counter_modulo8_sync_updown: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] jack;
  logic [WIDTH-1:0] kilby;
  logic             load_ok;
  logic             load_error_reg;

  assign load_ok = (int'(bus.load_value) < MODULUS);

  // Wrap is decided by comparison so non-power-of-two moduli and stray states recover.
  always_comb begin
    q_next = q;
    if (bus.load) begin
      if (load_ok) begin
        q_next = bus.load_value;
      end
    end else if (bus.enable) begin
      if (bus.count_down == DIR_DOWN) begin
        q_next = (q == '0 || q > MAX_VAL) ? MAX_VAL : q - 1'b1;
      end else begin
        q_next = (q >= MAX_VAL) ? '0 : q + 1'b1;
      end
    end
  end

  assign jack  = q_next & ~q;
  assign kilby = ~q_next & q;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      flipflop_jk_posedge_sync u_ff (
        .clockpulse (clockpulse),
        .clear      (clear),
        .jack       (jack[gi]),
        .kilby      (kilby[gi]),
        .signal_q   (q[gi]),
        .signal_q_  (q_n[gi])
      );
    end
  endgenerate

  always_ff @(posedge clockpulse) begin
    if (clear) begin
      load_error_reg <= 1'b0;
    end else begin
      load_error_reg <= bus.load & ~load_ok;
    end
  end

  assign bus.signal_q       = q;
  assign bus.signal_q_      = q_n;
  assign bus.load_error     = load_error_reg;
  assign bus.terminal_count = bus.enable & ~bus.load & ~clear &
                              ((bus.count_down == DIR_DOWN) ? (q == '0) : (q == MAX_VAL));

endmodule

// File: tb/tb_counter_modulo8_sync_updown.sv
// Self-checking bench: modulo-8 and modulo-6 counters plus a two-stage cascade,
// directed steps followed by random stimulus against an arithmetic reference model.
module tb_counter_modulo8_sync_updown;

  logic clockpulse = 1'b0;
  logic clear;

  always #5 clockpulse = ~clockpulse;

  counter_modulo8_sync_updown_if #(.WIDTH(3)) bus8();
  counter_modulo8_sync_updown_if #(.WIDTH(3)) bus6();
  counter_modulo8_sync_updown_if #(.WIDTH(3)) bus_lo();
  counter_modulo8_sync_updown_if #(.WIDTH(3)) bus_hi();

  counter_modulo8_sync_updown #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clockpulse (clockpulse), .clear (clear), .bus (bus8));
  counter_modulo8_sync_updown #(.WIDTH(3), .MODULUS(6)) dut6 (
    .clockpulse (clockpulse), .clear (clear), .bus (bus6));
  counter_modulo8_sync_updown #(.WIDTH(3), .MODULUS(8)) dut_lo (
    .clockpulse (clockpulse), .clear (clear), .bus (bus_lo));
  counter_modulo8_sync_updown #(.WIDTH(3), .MODULUS(8)) dut_hi (
    .clockpulse (clockpulse), .clear (clear), .bus (bus_hi));

  assign bus_hi.enable = bus_lo.terminal_count;

  // stimulus variables
  bit         en8, dn8, ld8;
  int         lv8;
  bit         en6, dn6, ld6;
  int         lv6;
  bit         enc, dnc, ldc;
  logic [5:0] lvc;

  // reference model state
  int m8, m6, mc;
  bit known;
  int n_checks;
  int n_fail;

  function automatic int next_val(int cur, int mod, bit clr, bit ld, int lv, bit en, bit dn);
    if (clr) return 0;
    if (ld) return (lv < mod) ? lv : cur;
    if (en) return dn ? (cur + mod - 1) % mod : (cur + 1) % mod;
    return cur;
  endfunction

  function automatic int tc_exp(int cur, int mod, bit clr, bit ld, bit en, bit dn);
    return (en && !ld && !clr && (dn ? (cur == 0) : (cur == mod - 1))) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int  e8, e6, ec, err6;
    bit  clr;
    clr = clear;
    bus8.enable = en8;  bus8.count_down = dn8;  bus8.load = ld8;  bus8.load_value = 3'(lv8);
    bus6.enable = en6;  bus6.count_down = dn6;  bus6.load = ld6;  bus6.load_value = 3'(lv6);
    bus_lo.enable = enc; bus_lo.count_down = dnc; bus_lo.load = ldc; bus_lo.load_value = lvc[2:0];
    bus_hi.count_down = dnc; bus_hi.load = ldc; bus_hi.load_value = lvc[5:3];
    #1;
    if (known) begin
      check("tc8", {31'b0, bus8.terminal_count}, tc_exp(m8, 8, clr, ld8, en8, dn8));
      check("tc6", {31'b0, bus6.terminal_count}, tc_exp(m6, 6, clr, ld6, en6, dn6));
      check("tc_lo", {31'b0, bus_lo.terminal_count}, tc_exp(mc % 8, 8, clr, ldc, enc, dnc));
    end
    e8 = next_val(m8, 8, clr, ld8, lv8, en8, dn8);
    e6 = next_val(m6, 6, clr, ld6, lv6, en6, dn6);
    ec = next_val(mc, 64, clr, ldc, int'(lvc), enc, dnc);
    err6 = (!clr && ld6 && lv6 >= 6) ? 1 : 0;
    @(posedge clockpulse);
    #1;
    m8 = e8; m6 = e6; mc = ec; known = 1'b1;
    check("q8", {29'b0, bus8.signal_q}, m8);
    check("q8_n", {29'b0, bus8.signal_q_}, 7 - m8);
    check("err8", {31'b0, bus8.load_error}, 0);
    check("q6", {29'b0, bus6.signal_q}, m6);
    check("q6_n", {29'b0, bus6.signal_q_}, 7 - m6);
    check("err6", {31'b0, bus6.load_error}, err6);
    check("casc", {26'b0, bus_hi.signal_q, bus_lo.signal_q}, mc);
    check("hi_n", {29'b0, bus_hi.signal_q_}, 7 - mc / 8);
    $display("cycle t=%0t clr=%0d q8=%0d q6=%0d casc=%0d", $time, clr, m8, m6, mc);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; known = 1'b0;
    m8 = 0; m6 = 0; mc = 0;
    en8 = 0; dn8 = 0; ld8 = 0; lv8 = 0;
    en6 = 0; dn6 = 0; ld6 = 0; lv6 = 0;
    enc = 0; dnc = 0; ldc = 0; lvc = '0;

    // reset from unknown state
    clear = 1'b1; cycle(); clear = 1'b0;
    check("rst_q", {29'b0, bus8.signal_q}, 0);
    check("rst_qn", {29'b0, bus8.signal_q_}, 7);

    // up count through the wrap
    en8 = 1; dn8 = 0;
    repeat (10) cycle();
    check("up10", {29'b0, bus8.signal_q}, 2);

    // down count from 0, then flip direction at 5
    clear = 1'b1; cycle(); clear = 1'b0;
    dn8 = 1;
    repeat (3) cycle();
    check("down3", {29'b0, bus8.signal_q}, 5);
    dn8 = 0; cycle();
    check("dirflip", {29'b0, bus8.signal_q}, 6);

    // load beats enable
    ld8 = 1; lv8 = 5; en8 = 1; cycle();
    check("ld_wins", {29'b0, bus8.signal_q}, 5);
    ld8 = 0; cycle();
    check("ld_then_up", {29'b0, bus8.signal_q}, 6);

    // modulo-6: illegal load, wrap both ways
    en6 = 0; ld6 = 1; lv6 = 3; cycle();
    lv6 = 6; cycle();
    check("ill_hold", {29'b0, bus6.signal_q}, 3);
    check("ill_err", {31'b0, bus6.load_error}, 1);
    ld6 = 0; cycle();
    check("err_pulse", {31'b0, bus6.load_error}, 0);
    ld6 = 1; lv6 = 5; cycle();
    ld6 = 0; en6 = 1; dn6 = 0; cycle();
    check("m6_up_wrap", {29'b0, bus6.signal_q}, 0);
    dn6 = 1; cycle();
    check("m6_dn_wrap", {29'b0, bus6.signal_q}, 5);

    // cascade borrow from 8'h10, then clear mid-count
    ldc = 1; lvc = 6'h10; cycle();
    ldc = 0; enc = 1; dnc = 1; cycle();
    check("casc_borrow", {26'b0, bus_hi.signal_q, bus_lo.signal_q}, 32'h0F);
    repeat (3) cycle();
    clear = 1'b1; ldc = 1; lvc = 6'h2A; cycle(); clear = 1'b0; ldc = 0;
    check("casc_clear", {26'b0, bus_hi.signal_q, bus_lo.signal_q}, 0);

    // random phase
    repeat (400) begin
      clear = ($urandom_range(0, 31) == 0);
      ld8 = ($urandom_range(0, 7) == 0); lv8 = $urandom_range(0, 7);
      en8 = $urandom_range(0, 1) != 0;   dn8 = $urandom_range(0, 1) != 0;
      ld6 = ($urandom_range(0, 5) == 0); lv6 = $urandom_range(0, 7);
      en6 = $urandom_range(0, 1) != 0;   dn6 = $urandom_range(0, 1) != 0;
      ldc = ($urandom_range(0, 15) == 0); lvc = 6'($urandom_range(0, 63));
      enc = $urandom_range(0, 3) != 0;   dnc = ($urandom_range(0, 7) < 3);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
